// File: rtl/cr_kme_key_tlv_pair_arb_if.sv
// cr_kme_key_tlv_pair_arb_if: lane-side paired TLV sources and compare/split encrypt/validate input ports
interface cr_kme_key_tlv_pair_arb_if #(
    parameter int N_LANES = 4,
    parameter int TLV_W   = 64
);
    logic [N_LANES-1:0]       lane_enc_valid, lane_enc_eot, lane_enc_ack;
    logic [N_LANES*TLV_W-1:0] lane_enc_tlv;
    logic [N_LANES-1:0]       lane_val_valid, lane_val_eot, lane_val_ack;
    logic [N_LANES*TLV_W-1:0] lane_val_tlv;
    logic                     enc_ob_wr, enc_ob_full, val_ob_wr, val_ob_full;
    logic [TLV_W-1:0]         enc_ob_tlv, val_ob_tlv;

    modport slave (
        input  lane_enc_valid, lane_enc_eot, lane_enc_tlv,
        input  lane_val_valid, lane_val_eot, lane_val_tlv,
        output lane_enc_ack, lane_val_ack,
        output enc_ob_wr, enc_ob_tlv, val_ob_wr, val_ob_tlv,
        input  enc_ob_full, val_ob_full
    );

    modport master (
        output lane_enc_valid, lane_enc_eot, lane_enc_tlv,
        output lane_val_valid, lane_val_eot, lane_val_tlv,
        input  lane_enc_ack, lane_val_ack,
        input  enc_ob_wr, enc_ob_tlv, val_ob_wr, val_ob_tlv,
        output enc_ob_full, val_ob_full
    );
endinterface

// File: rtl/cr_kme_key_tlv_pair_arb.sv
// cr_kme_key_tlv_pair_arb: packet-atomic round-robin arbiter for the paired encrypt/validate key TLV streams.
// Optional stall watchdog enabled by defining KME_KEY_ARB_WDOG_EN.
module cr_kme_key_tlv_pair_arb #(
    parameter int N_LANES = 4,
    parameter int TLV_W   = 64,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cr_kme_key_tlv_pair_arb_if.slave bus,
    output logic [N_LANES-1:0]   grant,
    output logic                 busy,
    output logic                 pair_len_miscmp_int,
    output logic                 arb_timeout_int
);
    localparam int PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state;
    logic [PW-1:0]      rr_ptr, g, sel, idx;
    logic [N_LANES-1:0] req;
    logic               enc_done, val_done, enc_wr, val_wr, enc_fin, val_fin, rel;
    logic [CNT_W-1:0]   enc_cnt, val_cnt, enc_nxt, val_nxt;

    assign req = bus.lane_enc_valid | bus.lane_val_valid;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        sel = rr_ptr;
        idx = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % N_LANES);
            if (req[idx]) sel = idx;
        end
    end

    assign enc_wr  = (state == XFER) & bus.lane_enc_valid[g] & ~bus.enc_ob_full & ~enc_done;
    assign val_wr  = (state == XFER) & bus.lane_val_valid[g] & ~bus.val_ob_full & ~val_done;
    assign enc_fin = enc_done | (enc_wr & bus.lane_enc_eot[g]);
    assign val_fin = val_done | (val_wr & bus.lane_val_eot[g]);
    assign rel     = (state == XFER) & enc_fin & val_fin;
    assign enc_nxt = enc_cnt + CNT_W'(enc_wr & ~&enc_cnt);
    assign val_nxt = val_cnt + CNT_W'(val_wr & ~&val_cnt);

    assign bus.enc_ob_wr    = enc_wr;
    assign bus.val_ob_wr    = val_wr;
    assign bus.enc_ob_tlv   = enc_wr ? bus.lane_enc_tlv[g*TLV_W +: TLV_W] : '0;
    assign bus.val_ob_tlv   = val_wr ? bus.lane_val_tlv[g*TLV_W +: TLV_W] : '0;
    assign bus.lane_enc_ack = grant & {N_LANES{enc_wr}};
    assign bus.lane_val_ack = grant & {N_LANES{val_wr}};

    // Counts include the releasing beat, so compare the next-state values.
    assign pair_len_miscmp_int = rel & (enc_nxt != val_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            g        <= '0;
            enc_done <= 1'b0;
            val_done <= 1'b0;
            enc_cnt  <= '0;
            val_cnt  <= '0;
        end else if (state == IDLE) begin
            enc_done <= 1'b0;
            val_done <= 1'b0;
            enc_cnt  <= '0;
            val_cnt  <= '0;
            if (|req) begin
                state <= XFER;
                g     <= sel;
                grant <= N_LANES'(1) << sel;
                busy  <= 1'b1;
            end
        end else if (rel) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= (g == PW'(N_LANES - 1)) ? '0 : g + 1'b1;
        end else begin
            enc_done <= enc_fin;
            val_done <= val_fin;
            enc_cnt  <= enc_nxt;
            val_cnt  <= val_nxt;
        end
    end

`ifdef KME_KEY_ARB_WDOG_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall;
    logic          stall_now;

    assign stall_now       = (state == XFER) & ~enc_wr & ~val_wr;
    assign arb_timeout_int = stall_now & (stall == SW'(TIMEOUT - 1));

    // Parks at TIMEOUT after firing so the pulse is not repeated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall <= '0;
        else if (state == IDLE || !stall_now) stall <= '0;
        else if (stall != SW'(TIMEOUT)) stall <= stall + 1'b1;
    end
`else
    assign arb_timeout_int = 1'b0;
`endif
endmodule
